// File: rtl/vec_input_feeder.sv
// vec_input_feeder
//   Input stage of the vector processor. Bytes from the host are buffered in a
//   circular FIFO and released to the core's next_in port as gap-free bursts
//   of exactly BURST elements. A burst only starts once a whole vector is
//   buffered, and at least one idle cycle separates consecutive bursts.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_data/in_valid    : host byte and its valid
//   in_ready            : FIFO not full (combinational from registered count)
//   en                  : allows a new burst to start (only looked at in IDLE)
//   next_in/next_valid  : registered element to the core, 0 when not valid
//   vec_start/vec_last  : first / last element of a burst
//   level               : current FIFO occupancy
module vec_input_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int BURST  = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       en,
  output logic [DATA_W-1:0]          next_in,
  output logic                       next_valid,
  output logic                       vec_start,
  output logic                       vec_last,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [BW-1:0]     beat_q;
  state_e            state_q;

  logic [DATA_W-1:0] next_in_q;
  logic              next_valid_q, vec_start_q, vec_last_q;

  logic push, pop, start;
  logic [DATA_W-1:0] head;

  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // A burst may only begin with a full vector on hand; after that STREAM pops
  // unconditionally, which cannot underflow.
  assign start    = (state_q == IDLE) && en && (count_q >= CW'(BURST));
  assign pop      = start || (state_q == STREAM);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage has no reset; stale contents are never read because count gates pops.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Burst FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      next_in_q    <= '0;
      next_valid_q <= 1'b0;
      vec_start_q  <= 1'b0;
      vec_last_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            next_in_q    <= head;
            next_valid_q <= 1'b1;
            vec_start_q  <= 1'b1;
            if (BURST == 1) begin
              // Single-element vector: first and last coincide.
              vec_last_q <= 1'b1;
              beat_q     <= '0;
              state_q    <= GAP;
            end else begin
              vec_last_q <= 1'b0;
              beat_q     <= BW'(1);
              state_q    <= STREAM;
            end
          end else begin
            next_in_q    <= '0;
            next_valid_q <= 1'b0;
            vec_start_q  <= 1'b0;
            vec_last_q   <= 1'b0;
          end
        end
        STREAM: begin
          next_in_q    <= head;
          next_valid_q <= 1'b1;
          vec_start_q  <= 1'b0;
          if (beat_q == BW'(BURST - 1)) begin
            vec_last_q <= 1'b1;
            beat_q     <= '0;
            state_q    <= GAP;
          end else begin
            vec_last_q <= 1'b0;
            beat_q     <= beat_q + 1'b1;
          end
        end
        GAP: begin
          // Forces one invalid cycle between vectors.
          next_in_q    <= '0;
          next_valid_q <= 1'b0;
          vec_start_q  <= 1'b0;
          vec_last_q   <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          next_in_q    <= '0;
          next_valid_q <= 1'b0;
          vec_start_q  <= 1'b0;
          vec_last_q   <= 1'b0;
          beat_q       <= '0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign next_in    = next_in_q;
  assign next_valid = next_valid_q;
  assign vec_start  = vec_start_q;
  assign vec_last   = vec_last_q;
  assign level      = count_q;

endmodule

// File: tb/tb_vec_input_feeder.sv
// Directed bench for vec_input_feeder: reset, single vector, partial vector,
// back-to-back vectors, full/backpressure, and mid-burst en/reset events.
module tb_vec_input_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       en;
  logic [7:0] next_in;
  logic       next_valid;
  logic       vec_start;
  logic       vec_last;
  logic [4:0] level;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] v20 [20];

  vec_input_feeder #(.DATA_W(8), .DEPTH(16), .BURST(10)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .en(en), .next_in(next_in), .next_valid(next_valid),
    .vec_start(vec_start), .vec_last(vec_last), .level(level)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled and inputs changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 8'haa; en = 1'b0;
    tick(); tick();
    vectors++; if (next_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", next_valid); end
    vectors++; if (next_in !== 8'h00) begin miscompares++; $display("FAIL rst_next_in got %h want 00", next_in); end
    vectors++; if (vec_start !== 1'b0 || vec_last !== 1'b0) begin miscompares++; $display("FAIL rst_delims got %b%b want 00", vec_start, vec_last); end
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL rst_level got %0d want 0", level); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    reset = 1'b0; in_valid = 1'b0;
    tick();
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL rst_no_accept level got %0d want 0", level); end
  endtask

  task automatic test_single();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = v20[i]; in_valid = 1'b1;
      tick();
      vectors++; if (next_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid byte %0d got %b want 0", i, next_valid); end
    end
    in_valid = 1'b0;
    vectors++; if (level !== 5'd10) begin miscompares++; $display("FAIL single_level_full got %0d want 10", level); end
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (next_valid !== 1'b1 || next_in !== v20[k] || vec_start !== (k == 0) || vec_last !== (k == 9)) begin
        miscompares++;
        $display("FAIL single_elem%0d got v=%b d=%h s=%b l=%b want v=1 d=%h s=%b l=%b",
                 k, next_valid, next_in, vec_start, vec_last, v20[k], k == 0, k == 9);
      end
    end
    tick();
    vectors++; if (next_valid !== 1'b0 || next_in !== 8'h00) begin miscompares++; $display("FAIL single_gap got v=%b d=%h want 0 00", next_valid, next_in); end
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL single_level_end got %0d want 0", level); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_partial();
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = 8'(i + 1); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      vectors++; if (next_valid !== 1'b0) begin miscompares++; $display("FAIL partial_valid cycle %0d got %b want 0", c, next_valid); end
    end
    vectors++; if (level !== 5'd9) begin miscompares++; $display("FAIL partial_level got %0d want 9", level); end
    in_data = 8'h0a; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if (next_valid !== 1'b0 || level !== 5'd10) begin miscompares++; $display("FAIL partial_counted got v=%b lvl=%0d want 0 10", next_valid, level); end
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (next_valid !== 1'b1 || next_in !== 8'(k + 1) || vec_start !== (k == 0) || vec_last !== (k == 9)) begin
        miscompares++;
        $display("FAIL partial_elem%0d got v=%b d=%h s=%b l=%b want d=%h", k, next_valid, next_in, vec_start, vec_last, 8'(k + 1));
      end
    end
    tick();
    vectors++; if (next_valid !== 1'b0) begin miscompares++; $display("FAIL partial_gap got %b want 0", next_valid); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_data = v20[i]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    vectors++; if (level !== 5'd16 || in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_fill got lvl=%0d rdy=%b want 16 0", level, in_ready); end
    en = 1'b1;
    // Only 16 of the 20 were accepted (the rest were offered while full), so
    // push the last four again once room opens, tracking acceptance.
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 10; k++) begin
        if (b == 0 && k >= 1 && k <= 4) begin
          in_data = v20[15 + k]; in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
        tick();
        vectors++;
        if (next_valid !== 1'b1 || next_in !== v20[b*10 + k] || vec_start !== (k == 0) || vec_last !== (k == 9)) begin
          miscompares++;
          $display("FAIL b2b_b%0d_e%0d got v=%b d=%h s=%b l=%b want d=%h", b, k, next_valid, next_in, vec_start, vec_last, v20[b*10 + k]);
        end
      end
      in_valid = 1'b0;
      tick();
      vectors++; if (next_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_gap%0d got %b want 0", b, next_valid); end
    end
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL b2b_level_end got %0d want 0", level); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_full();
    en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'h10 + 8'(i); in_valid = 1'b1;
      tick();
    end
    in_data = 8'h20;
    tick();
    vectors++; if (in_ready !== 1'b0 || level !== 5'd16) begin miscompares++; $display("FAIL full_block got rdy=%b lvl=%0d want 0 16", in_ready, level); end
    en = 1'b1;
    tick();
    vectors++; if (next_in !== 8'h10 || vec_start !== 1'b1 || level !== 5'd15 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL full_first got d=%h s=%b lvl=%0d rdy=%b want 10 1 15 1", next_in, vec_start, level, in_ready);
    end
    tick();
    in_valid = 1'b0;
    vectors++; if (next_in !== 8'h11 || level !== 5'd15) begin miscompares++; $display("FAIL full_pushpop got d=%h lvl=%0d want 11 15", next_in, level); end
    for (int k = 2; k < 10; k++) begin
      tick();
      vectors++; if (next_valid !== 1'b1 || next_in !== 8'h10 + 8'(k) || vec_last !== (k == 9)) begin
        miscompares++; $display("FAIL full_b0_e%0d got v=%b d=%h l=%b want d=%h", k, next_valid, next_in, vec_last, 8'h10 + 8'(k));
      end
    end
    tick();
    vectors++; if (next_valid !== 1'b0 || level !== 5'd7) begin miscompares++; $display("FAIL full_gap got v=%b lvl=%0d want 0 7", next_valid, level); end
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h21 + 8'(i); in_valid = 1'b1;
      tick();
      vectors++; if (next_valid !== 1'b0) begin miscompares++; $display("FAIL full_wait%0d got %b want 0", i, next_valid); end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++; if (next_valid !== 1'b1 || next_in !== 8'h1a + 8'(k) || vec_start !== (k == 0) || vec_last !== (k == 9)) begin
        miscompares++; $display("FAIL full_b1_e%0d got v=%b d=%h s=%b l=%b want d=%h", k, next_valid, next_in, vec_start, vec_last, 8'h1a + 8'(k));
      end
    end
    tick();
    vectors++; if (next_valid !== 1'b0 || level !== 5'd0) begin miscompares++; $display("FAIL full_end got v=%b lvl=%0d want 0 0", next_valid, level); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_mid_burst();
    // en dropped at element 4: burst must still complete.
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'h30 + 8'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 3) en = 1'b0;
      vectors++; if (next_valid !== 1'b1 || next_in !== 8'h30 + 8'(k) || vec_last !== (k == 9)) begin
        miscompares++; $display("FAIL en_drop_e%0d got v=%b d=%h l=%b want d=%h", k, next_valid, next_in, vec_last, 8'h30 + 8'(k));
      end
    end
    tick();
    vectors++; if (next_valid !== 1'b0) begin miscompares++; $display("FAIL en_drop_gap got %b want 0", next_valid); end
    // Reset at element 4: burst aborts and buffer empties.
    for (int i = 0; i < 10; i++) begin
      in_data = 8'h40 + 8'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (next_in !== 8'h40 + 8'(k)) begin miscompares++; $display("FAIL rst_mid_e%0d got %h want %h", k, next_in, 8'h40 + 8'(k)); end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if (next_valid !== 1'b0 || next_in !== 8'h00 || level !== 5'd0) begin
      miscompares++; $display("FAIL rst_mid_abort got v=%b d=%h lvl=%0d want 0 00 0", next_valid, next_in, level);
    end
    for (int c = 0; c < 15; c++) begin
      tick();
      vectors++; if (next_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_after%0d got %b want 0", c, next_valid); end
    end
    en = 1'b0;
  endtask

  initial begin
    v20 = '{8'h7f, 8'h04, 8'hf4, 8'hec, 8'h44, 8'h3f, 8'h36, 8'hb0, 8'h21, 8'hae,
            8'h8f, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'hde, 8'hf0, 8'h4e};
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; en = 1'b0;
    test_reset();
    test_single();
    test_partial();
    test_back_to_back();
    test_full();
    test_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
